xb_packer: RTL and testbench



---
 rtl/xb_packer.sv | 210 +++++++++++++++++++++
 tb/tb_xb_packer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xb_packer.sv
// xb_packer: packs 3-byte camera samples into 32-bit host-link words.
// Optional trailer/sample counter: define XB_PACKER_STATS_EN.
module xb_packer #(
  parameter int DELAY         = 1,
  parameter int XB_SIZE       = 32,
  parameter int N_CAM         = 3,
  parameter int COMPRESS_SIZE = 8,
  parameter int FIFO_AW       = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               in_valid,
  input  logic [XB_SIZE-1:0] in_data,
  input  logic               xb_full,
  output logic               xb_wren,
  output logic [XB_SIZE-1:0] xb_data,
  output logic               overflow,
  output logic [15:0]        drop_count,
  output logic               frame_active
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int SW    = N_CAM * COMPRESS_SIZE;
  localparam logic [FIFO_AW:0] DEPTH_W =
    (FIFO_AW+1)'(DEPTH);
  localparam int unused_delay = DELAY;

  typedef logic [XB_SIZE-1:0] word_t;

  logic               vin_q;
  word_t              din_q;
  logic [1:0]         phase_q;
  logic [SW-1:0]      res_q;
  word_t              mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q;
  logic [FIFO_AW-1:0] rd_q;
  logic [FIFO_AW:0]   cnt_q;
  logic               ovf_q;
  logic [15:0]        drop_q;
  logic               active_q;

  logic          is_sof;
  logic          is_smp;
  logic [SW-1:0] pay;
  logic          has_flush;
  logic          has_trl;
  word_t         trl_w;
  word_t         flush_w;

  assign is_sof    = din_q[31:30] == 2'b01;
  assign is_smp    = din_q[31:30] == 2'b00;
  assign pay       = din_q[SW-1:0];
  assign has_flush = phase_q != 2'd0;
  assign flush_w   = {8'h00, res_q};

  // Sample path: phase is the number of residue bytes held
  word_t         smp_w;
  logic          smp_n;
  logic [1:0]    smp_phase;
  logic [SW-1:0] smp_res;

  always_comb begin
    smp_w     = '0;
    smp_n     = 1'b1;
    smp_phase = 2'd0;
    smp_res   = '0;
    unique case (phase_q)
      2'd0: begin
        smp_n     = 1'b0;
        smp_phase = 2'd3;
        smp_res   = pay;
      end
      2'd3: begin
        smp_w     = {pay[7:0], res_q};
        smp_phase = 2'd2;
        smp_res   = {8'h00, pay[23:8]};
      end
      2'd2: begin
        smp_w     = {pay[15:0], res_q[15:0]};
        smp_phase = 2'd1;
        smp_res   = {16'h0000, pay[23:16]};
      end
      default: begin
        smp_w     = {pay, res_q[7:0]};
      end
    endcase
  end

  word_t         w0;
  word_t         w1;
  logic [1:0]    need;
  logic [1:0]    phase_d;
  logic [SW-1:0] res_d;

  always_comb begin
    w0      = din_q;
    w1      = din_q;
    need    = 2'd0;
    phase_d = phase_q;
    res_d   = res_q;
    unique case (1'b1)
      is_sof: begin
        if (has_flush) begin
          w0 = flush_w;
          w1 = has_trl ? trl_w : din_q;
        end else if (has_trl) begin
          w0 = trl_w;
        end
        need = 2'd1 + {1'b0, has_flush}
                    + {1'b0, has_trl};
        phase_d = 2'd0;
        res_d   = '0;
      end
      default: begin
        w0      = smp_w;
        need    = {1'b0, smp_n};
        phase_d = smp_phase;
        res_d   = smp_res;
      end
    endcase
  end

  logic [FIFO_AW:0] free_w;
  logic [FIFO_AW:0] push_w;
  logic [FIFO_AW:0] pop_w;
  logic [FIFO_AW:0] cnt_d;
  logic             take;
  logic             fits;
  logic             accept;
  logic             drop;

  assign free_w = DEPTH_W - cnt_q;
  assign take   = vin_q && (is_sof || is_smp);
  assign fits   = (FIFO_AW+1)'(need) <= free_w;
  assign accept = take && fits;
  assign drop   = take && !fits;
  assign push_w = accept ? (FIFO_AW+1)'(need) : '0;
  assign pop_w  = (FIFO_AW+1)'(xb_wren);
  assign cnt_d  = cnt_q + push_w - pop_w;

  assign xb_wren      = (cnt_q != '0) && !xb_full;
  assign xb_data      = mem_q[rd_q];
  assign overflow     = ovf_q;
  assign drop_count   = drop_q;
  assign frame_active = active_q;

`ifdef XB_PACKER_STATS_EN
  logic [19:0] scnt_q;

  assign has_trl = active_q;
  assign trl_w   = {2'b10, 10'h000, scnt_q};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scnt_q <= '0;
    end else if (accept) begin
      if (is_sof) scnt_q <= '0;
      else        scnt_q <= scnt_q + 20'd1;
    end
  end
`else
  assign has_trl = 1'b0;
  assign trl_w   = '0;
`endif

  // Storage has no reset; pointers define what is valid
  always_ff @(posedge CLK) begin
    if (accept) begin
      if (need >= 2'd1) mem_q[wr_q] <= w0;
      if (need >= 2'd2)
        mem_q[wr_q + FIFO_AW'(1)] <= w1;
`ifdef XB_PACKER_STATS_EN
      if (need == 2'd3)
        mem_q[wr_q + FIFO_AW'(2)] <= din_q;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vin_q    <= 1'b0;
      din_q    <= '0;
      phase_q  <= 2'd0;
      res_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      active_q <= 1'b0;
    end else begin
      vin_q <= in_valid;
      din_q <= in_data;
      cnt_q <= cnt_d;
      if (accept) begin
        phase_q <= phase_d;
        res_q   <= res_d;
        wr_q    <= wr_q + FIFO_AW'(need);
        if (is_sof) active_q <= 1'b1;
      end
      if (xb_wren) rd_q <= rd_q + FIFO_AW'(1);
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != 16'hFFFF)
          drop_q <= drop_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_xb_packer.sv
// tb_xb_packer: vector table plus scoreboard for xb_packer.
// Tracks the XB_PACKER_STATS_EN build when that macro is defined.
module tb_xb_packer;

  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        xb_full = 1'b0;
  logic        xb_wren;
  logic [31:0] xb_data;
  logic        overflow;
  logic [15:0] drop_count;
  logic        frame_active;

  always #5 CLK = ~CLK;

  xb_packer dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .xb_full     (xb_full),
    .xb_wren     (xb_wren),
    .xb_data     (xb_data),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .frame_active(frame_active)
  );

  typedef struct {
    logic [31:0] din;
    int          n;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t        tv[$];
  logic [31:0] sb[$];
  logic [7:0]  res[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (xb_wren === 1'b1) begin
      n_wr++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL stray_write: got %h want none",
                 xb_data);
      end else begin
        check("xb_data", xb_data, sb.pop_front());
      end
    end
  end

  task automatic drain(input string name,
                       input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(posedge CLK);
      k++;
    end
    repeat (3) @(posedge CLK);
    #1;
    check(name, sb.size(), 0);
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int occ;
    int drops;
    int need;
    int wr0;
    logic [31:0] w;

    tv.push_back('{32'h4000_0005, 1,
                   32'h4000_0005, 0, 0});
    tv.push_back('{32'h0003_0201, 0, 0, 0, 0});
    tv.push_back('{32'h0006_0504, 1,
                   32'h0403_0201, 0, 0});
    tv.push_back('{32'h0009_0807, 1,
                   32'h0807_0605, 0, 0});
    tv.push_back('{32'h000C_0B0A, 1,
                   32'h0C0B_0A09, 0, 0});
    tv.push_back('{32'h0033_2211, 0, 0, 0, 0});
`ifdef XB_PACKER_STATS_EN
    tv.push_back('{32'h4000_0006, 3, 32'h0033_2211,
                   32'h8000_0005, 32'h4000_0006});
`else
    tv.push_back('{32'h4000_0006, 2, 32'h0033_2211,
                   32'h4000_0006, 0});
`endif
    tv.push_back('{32'h0066_5544, 0, 0, 0, 0});
    tv.push_back('{32'hFFFF_FFFF, 0, 0, 0, 0});
    tv.push_back('{32'h0099_8877, 1,
                   32'h7766_5544, 0, 0});
    tv.push_back('{32'h8000_0000, 0, 0, 0, 0});
    tv.push_back('{32'h00CC_BBAA, 1,
                   32'hBBAA_9988, 0, 0});
    tv.push_back('{32'h00FF_EEDD, 1,
                   32'hFFEE_DDCC, 0, 0});
`ifdef XB_PACKER_STATS_EN
    tv.push_back('{32'h4000_0007, 2, 32'h8000_0004,
                   32'h4000_0007, 0});
`else
    tv.push_back('{32'h4000_0007, 1,
                   32'h4000_0007, 0, 0});
`endif
    tv.push_back('{32'h0013_1211, 0, 0, 0, 0});
    tv.push_back('{32'h0016_1514, 1,
                   32'h1413_1211, 0, 0});
    tv.push_back('{32'h0019_1817, 1,
                   32'h1817_1615, 0, 0});
    tv.push_back('{32'h001C_1B1A, 1,
                   32'h1C1B_1A19, 0, 0});
    tv.push_back('{32'h001F_1E1D, 0, 0, 0, 0});
`ifdef XB_PACKER_STATS_EN
    tv.push_back('{32'h4000_0008, 3, 32'h001F_1E1D,
                   32'h8000_0005, 32'h4000_0008});
`else
    tv.push_back('{32'h4000_0008, 2, 32'h001F_1E1D,
                   32'h4000_0008, 0});
`endif

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_wren", xb_wren, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_count, 0);
    check("rst_active", frame_active, 0);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Vector table: packing, flush, reserved words
    foreach (tv[i]) begin
      if (tv[i].n >= 1) sb.push_back(tv[i].e0);
      if (tv[i].n >= 2) sb.push_back(tv[i].e1);
      if (tv[i].n >= 3) sb.push_back(tv[i].e2);
      send(tv[i].din);
      @(posedge CLK);
      #1;
    end
    drain("table_drain", 40);
    check("table_ovf", overflow, 0);
    check("table_drop", drop_count, 0);
    check("table_active", frame_active, 1);

    // Backpressure: fill, drop, then drain across the wrap
    xb_full = 1'b1;
    wr0   = n_wr;
    occ   = 0;
    drops = 0;
    res.delete();
    for (int i = 0; i < 40; i++) begin
      logic [7:0] b0, b1, b2;
      b0 = 8'(3 * i);
      b1 = 8'(3 * i + 1);
      b2 = 8'(3 * i + 2);
      need = (res.size() + 3) / 4;
      if (occ + need > DEPTH) begin
        drops++;
      end else begin
        res.push_back(b0);
        res.push_back(b1);
        res.push_back(b2);
        while (res.size() >= 4) begin
          w = {res[3], res[2], res[1], res[0]};
          repeat (4) void'(res.pop_front());
          sb.push_back(w);
        end
        occ += need;
      end
      in_valid = 1'b1;
      in_data  = {8'h00, b2, b1, b0};
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("full_no_wren", n_wr - wr0, 0);
    check("full_ovf", overflow, 1);
    check("full_drop_model", drop_count, drops);
    check("full_drop_18", drop_count, 18);
    xb_full = 1'b0;
    drain("wrap_drain", 60);
    check("wrap_count", n_wr - wr0, DEPTH);

    // Async reset mid-frame, buffered words discarded
    xb_full = 1'b1;
    send(32'h4000_0009);
    send(32'h0052_5150);
    send(32'h0055_5453);
    repeat (3) @(posedge CLK);
    #3;
    check("pre_rst_active", frame_active, 1);
    RESET   = 1'b1;
    xb_full = 1'b0;
    #1;
    check("arst_wren", xb_wren, 0);
    check("arst_ovf", overflow, 0);
    check("arst_drop", drop_count, 0);
    check("arst_active", frame_active, 0);
    #2;
    RESET = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("post_rst_idle", sb.size(), 0);

    sb.push_back(32'h4000_000A);
    send(32'h4000_000A);
    send(32'h0003_0201);
    sb.push_back(32'h0003_0201);
`ifdef XB_PACKER_STATS_EN
    sb.push_back(32'h8000_0001);
`endif
    sb.push_back(32'h4000_000B);
    send(32'h4000_000B);
    drain("final_drain", 40);
    check("final_active", frame_active, 1);
    check("final_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
